block_digital_core: RTL and testbench

BLOCK_DIGITAL_CORE -- requirements
Module: block_digital_core

---
 rtl/block_digital_core_if.sv | 14 +
 rtl/block_digital_core.sv | 260 ++++++++++++++++++++++++++
 tb/tb_block_digital_core.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_digital_core_if.sv
// Command bus of block_digital_core: register op code, target address, write data
// and the read-drive flag that accompanies the tri-state data_out pin.
interface block_digital_core_if;
    // code/addr/data_in are sampled on every rising clk_3p2M edge. There is no
    // valid/ready pair: an op other than write/read is an idle cycle. data_oe is
    // high exactly while the block drives data_out (combinational read path).
    logic [5:0]  code;
    logic [9:0]  addr;
    logic [15:0] data_in;
    logic        data_oe;

    modport master (output code, output addr, output data_in, input data_oe);
    modport slave  (input code, input addr, input data_in, output data_oe);
endinterface

// File: rtl/block_digital_core.sv
// Digital core: register file, auto-zero clocks, 4-channel 12-bit SAR sequencer and daisy chain.
// Define BLOCK_DIGITAL_READBACK_EN to add the register readback path and STATUS register.
module block_digital_core (
    input  logic                       clk_3p2M,
    input  logic                       rst_n,
    block_digital_core_if.slave        bus,
    input  logic [7:0]                 reg_map_addr,
    output wire  [15:0]                data_out,
    output logic [11:0]                Rec_0,
    output logic [11:0]                Rec_1,
    output logic [11:0]                Rec_2,
    output logic [11:0]                Rec_3,
    output logic [8:0]                 STIM_AMP_0,
    output logic [8:0]                 STIM_AMP_1,
    output logic [8:0]                 STIM_AMP_2,
    output logic [8:0]                 STIM_AMP_3,
    output logic                       OFF_STIM_0,
    output logic                       OFF_STIM_1,
    output logic                       OFF_STIM_2,
    output logic                       OFF_STIM_3,
    output logic                       AMP_ON_0,
    output logic                       AMP_ON_1,
    output logic                       AMP_ON_2,
    output logic                       AMP_ON_3,
    output logic                       AMP_X50_0,
    output logic                       AMP_X50_1,
    output logic                       AMP_X50_2,
    output logic                       AMP_X50_3,
    output logic                       AZ_CLK_0,
    output logic                       AZ_CLK_1,
    output logic                       AZ_CLK_2,
    output logic                       AZ_CLK_3,
    output logic                       AZ_CLK_N_0,
    output logic                       AZ_CLK_N_1,
    output logic                       AZ_CLK_N_2,
    output logic                       AZ_CLK_N_3,
    output logic [3:0]                 SW_ANO_N_0,
    output logic [3:0]                 SW_ANO_N_1,
    output logic [3:0]                 SW_ANO_N_2,
    output logic [3:0]                 SW_ANO_N_3,
    output logic [3:0]                 SW_CAN_0,
    output logic [3:0]                 SW_CAN_1,
    output logic [3:0]                 SW_CAN_2,
    output logic [3:0]                 SW_CAN_3,
    output logic [3:0]                 CB_CHNL_0,
    output logic [3:0]                 CB_CHNL_1,
    output logic [3:0]                 CB_CHNL_2,
    output logic [3:0]                 CB_CHNL_3,
    input  logic                       AMP_OUT_0,
    input  logic                       AMP_OUT_1,
    input  logic                       AMP_OUT_2,
    input  logic                       AMP_OUT_3,
    output logic [7:0]                 elec_mux,
    output logic [3:0]                 D_HP,
    input  logic [3:0]                 COMP,
    output logic                       SAMP,
    output logic                       SAMP_analog,
    output logic                       WP0,
    output logic                       WP1,
    output logic                       WP2,
    output logic                       WP3,
    input  logic [12:0]                data_from_pre,
    output logic [12:0]                data_to_post,
    output logic [5:0]                 o_dbg_frame_cnt
);

    localparam logic [1:0] OP_WRITE = 2'b01;

    logic [11:0] r_rec  [4];
    logic [11:0] r_stim [4];
    logic [11:0] r_sw   [4];
    logic [11:0] r_misc;

    logic [1:0]  w_op;
    logic [3:0]  w_idx;
    logic        w_local;
    logic        w_bcast;
    logic        w_wr;
    logic [3:0]  w_amp_out;
    logic        w_unused;

    assign w_op      = bus.code[5:4];
    assign w_idx     = bus.code[3:0];
    assign w_local   = (bus.addr[9:8] == 2'b00) && (bus.addr[7:0] == reg_map_addr);
    assign w_bcast   = (bus.addr == 10'h3FF);
    assign w_wr      = (w_op == OP_WRITE) && (w_local || w_bcast);
    assign w_amp_out = {AMP_OUT_3, AMP_OUT_2, AMP_OUT_1, AMP_OUT_0};

    // Indices 13..15 fall through untouched: STATUS is read-only, 14/15 reserved.
    always_ff @(posedge clk_3p2M or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                r_rec[n]  <= 12'h000;
                r_stim[n] <= 12'h000;
                r_sw[n]   <= 12'h00F;
            end
            r_misc <= 12'h000;
        end else if (w_wr) begin
            case (w_idx[3:2])
                2'd0: r_rec[w_idx[1:0]]  <= bus.data_in[11:0];
                2'd1: r_stim[w_idx[1:0]] <= bus.data_in[11:0];
                2'd2: r_sw[w_idx[1:0]]   <= bus.data_in[11:0];
                2'd3: if (w_idx[1:0] == 2'd0) r_misc <= bus.data_in[11:0];
            endcase
        end
    end

    // Frame sequencer. r_active holds the count at 0 for the first edge after reset,
    // so the first post-reset frame shows SAMP for two full clocks like every other.
    logic        r_active;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [3:0]  w_sar_bit;
    logic        r_samp;
    logic        r_samp_an;
    logic [3:0]  r_wp;
    logic [11:0] r_result [4];
    logic [12:0] r_shift  [4];

    assign w_cnt_nxt = r_active ? r_cnt + 6'd1 : 6'd0;
    assign w_sar_bit = 4'(6'd13 - r_cnt);

    always_ff @(posedge clk_3p2M or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_cnt     <= 6'd0;
            r_samp    <= 1'b0;
            r_samp_an <= 1'b0;
            r_wp      <= 4'h0;
            for (int n = 0; n < 4; n++) begin
                r_result[n] <= 12'h000;
                r_shift[n]  <= 13'h1FFF;
            end
        end else begin
            r_active  <= 1'b1;
            r_cnt     <= w_cnt_nxt;
            r_samp    <= (w_cnt_nxt < 6'd2);
            r_samp_an <= (w_cnt_nxt < 6'd3);
            if (r_active) begin
                if (r_cnt >= 6'd2 && r_cnt <= 6'd13) begin
                    for (int n = 0; n < 4; n++) r_result[n][w_sar_bit] <= COMP[n];
                    r_wp <= COMP;
                end else begin
                    r_wp <= 4'h0;
                end
                if (r_cnt == 6'd15) begin
                    for (int n = 0; n < 4; n++)
                        r_shift[n] <= {1'b0, r_rec[n][0] ? r_result[n] : 12'h000};
                end else begin
                    for (int n = 0; n < 3; n++) r_shift[n] <= r_shift[n + 1];
                    r_shift[3] <= data_from_pre;
                end
            end
        end
    end

    // Auto-zero clocks share frame-count bit 4: 16 clocks high, 16 low.
    logic [3:0] w_az;
    always_comb begin
        w_az = 4'h0;
        for (int n = 0; n < 4; n++) w_az[n] = r_stim[n][10] & r_cnt[4];
    end

`ifdef BLOCK_DIGITAL_READBACK_EN
    logic [3:0]  r_amp_s1;
    logic [3:0]  r_amp_s2;
    logic [11:0] w_rd_word;
    logic        w_rd;

    always_ff @(posedge clk_3p2M or negedge rst_n) begin
        if (!rst_n) begin
            r_amp_s1 <= 4'h0;
            r_amp_s2 <= 4'h0;
        end else begin
            r_amp_s1 <= w_amp_out;
            r_amp_s2 <= r_amp_s1;
        end
    end

    always_comb begin
        w_rd_word = 12'h000;
        case (w_idx[3:2])
            2'd0:    w_rd_word = r_rec[w_idx[1:0]];
            2'd1:    w_rd_word = r_stim[w_idx[1:0]];
            2'd2:    w_rd_word = r_sw[w_idx[1:0]];
            default: begin
                if (w_idx == 4'd12)      w_rd_word = r_misc;
                else if (w_idx == 4'd13) w_rd_word = {8'h00, r_amp_s2};
            end
        endcase
    end

    // Broadcast never has addr[9:8]==0, so w_local alone excludes it from reads.
    assign w_rd        = (w_op == 2'b10) && w_local;
    assign bus.data_oe = w_rd;
    assign data_out    = w_rd ? {4'h0, w_rd_word} : 16'hzzzz;
    assign w_unused    = ^bus.data_in[15:12];
`else
    assign bus.data_oe = 1'b0;
    assign data_out    = 16'hzzzz;
    assign w_unused    = ^{w_amp_out, bus.data_in[15:12]};
`endif

    assign Rec_0 = r_rec[0];
    assign Rec_1 = r_rec[1];
    assign Rec_2 = r_rec[2];
    assign Rec_3 = r_rec[3];

    assign STIM_AMP_0 = r_stim[0][8:0];
    assign STIM_AMP_1 = r_stim[1][8:0];
    assign STIM_AMP_2 = r_stim[2][8:0];
    assign STIM_AMP_3 = r_stim[3][8:0];
    assign OFF_STIM_0 = r_stim[0][9];
    assign OFF_STIM_1 = r_stim[1][9];
    assign OFF_STIM_2 = r_stim[2][9];
    assign OFF_STIM_3 = r_stim[3][9];
    assign AMP_ON_0   = r_stim[0][10];
    assign AMP_ON_1   = r_stim[1][10];
    assign AMP_ON_2   = r_stim[2][10];
    assign AMP_ON_3   = r_stim[3][10];
    assign AMP_X50_0  = r_stim[0][11];
    assign AMP_X50_1  = r_stim[1][11];
    assign AMP_X50_2  = r_stim[2][11];
    assign AMP_X50_3  = r_stim[3][11];

    assign AZ_CLK_0   = w_az[0];
    assign AZ_CLK_1   = w_az[1];
    assign AZ_CLK_2   = w_az[2];
    assign AZ_CLK_3   = w_az[3];
    assign AZ_CLK_N_0 = ~w_az[0];
    assign AZ_CLK_N_1 = ~w_az[1];
    assign AZ_CLK_N_2 = ~w_az[2];
    assign AZ_CLK_N_3 = ~w_az[3];

    assign SW_ANO_N_0 = r_sw[0][3:0];
    assign SW_ANO_N_1 = r_sw[1][3:0];
    assign SW_ANO_N_2 = r_sw[2][3:0];
    assign SW_ANO_N_3 = r_sw[3][3:0];
    assign SW_CAN_0   = r_sw[0][7:4];
    assign SW_CAN_1   = r_sw[1][7:4];
    assign SW_CAN_2   = r_sw[2][7:4];
    assign SW_CAN_3   = r_sw[3][7:4];
    assign CB_CHNL_0  = r_sw[0][11:8];
    assign CB_CHNL_1  = r_sw[1][11:8];
    assign CB_CHNL_2  = r_sw[2][11:8];
    assign CB_CHNL_3  = r_sw[3][11:8];

    assign elec_mux = r_misc[7:0];
    assign D_HP     = r_misc[11:8];

    assign SAMP            = r_samp;
    assign SAMP_analog     = r_samp_an;
    assign WP0             = r_wp[0];
    assign WP1             = r_wp[1];
    assign WP2             = r_wp[2];
    assign WP3             = r_wp[3];
    assign data_to_post    = r_shift[0];
    assign o_dbg_frame_cnt = r_cnt;

endmodule

// File: tb/tb_block_digital_core.sv
// Self-checking bench for block_digital_core: directed scenarios plus randomized traffic
// compared every cycle against a register/frame reference model.
`timescale 1ns/1ps
module tb_block_digital_core;

    // ---------------- clock / reset ----------------
    logic clk_3p2M = 1'b0;
    logic rst_n;
    always #5 clk_3p2M = ~clk_3p2M;

    block_digital_core_if bus ();

    logic [7:0]        reg_map_addr;
    logic [3:0]        amp_out;
    logic [3:0]        comp;
    logic [12:0]       data_from_pre;
    wire  [15:0]       data_out;
    wire  [3:0][11:0]  rec;
    wire  [3:0][8:0]   stim_amp;
    wire  [3:0]        off_stim, amp_on, amp_x50, az_clk, az_clk_n;
    wire  [3:0][3:0]   sw_ano_n, sw_can, cb_chnl;
    wire  [7:0]        elec_mux;
    wire  [3:0]        d_hp;
    wire               samp, samp_an;
    wire  [3:0]        wp;
    wire  [12:0]       data_to_post;
    wire  [5:0]        dbg_cnt;

    block_digital_core dut (
        .clk_3p2M(clk_3p2M), .rst_n(rst_n), .bus(bus.slave), .reg_map_addr(reg_map_addr),
        .data_out(data_out),
        .Rec_0(rec[0]), .Rec_1(rec[1]), .Rec_2(rec[2]), .Rec_3(rec[3]),
        .STIM_AMP_0(stim_amp[0]), .STIM_AMP_1(stim_amp[1]), .STIM_AMP_2(stim_amp[2]), .STIM_AMP_3(stim_amp[3]),
        .OFF_STIM_0(off_stim[0]), .OFF_STIM_1(off_stim[1]), .OFF_STIM_2(off_stim[2]), .OFF_STIM_3(off_stim[3]),
        .AMP_ON_0(amp_on[0]), .AMP_ON_1(amp_on[1]), .AMP_ON_2(amp_on[2]), .AMP_ON_3(amp_on[3]),
        .AMP_X50_0(amp_x50[0]), .AMP_X50_1(amp_x50[1]), .AMP_X50_2(amp_x50[2]), .AMP_X50_3(amp_x50[3]),
        .AZ_CLK_0(az_clk[0]), .AZ_CLK_1(az_clk[1]), .AZ_CLK_2(az_clk[2]), .AZ_CLK_3(az_clk[3]),
        .AZ_CLK_N_0(az_clk_n[0]), .AZ_CLK_N_1(az_clk_n[1]), .AZ_CLK_N_2(az_clk_n[2]), .AZ_CLK_N_3(az_clk_n[3]),
        .SW_ANO_N_0(sw_ano_n[0]), .SW_ANO_N_1(sw_ano_n[1]), .SW_ANO_N_2(sw_ano_n[2]), .SW_ANO_N_3(sw_ano_n[3]),
        .SW_CAN_0(sw_can[0]), .SW_CAN_1(sw_can[1]), .SW_CAN_2(sw_can[2]), .SW_CAN_3(sw_can[3]),
        .CB_CHNL_0(cb_chnl[0]), .CB_CHNL_1(cb_chnl[1]), .CB_CHNL_2(cb_chnl[2]), .CB_CHNL_3(cb_chnl[3]),
        .AMP_OUT_0(amp_out[0]), .AMP_OUT_1(amp_out[1]), .AMP_OUT_2(amp_out[2]), .AMP_OUT_3(amp_out[3]),
        .elec_mux(elec_mux), .D_HP(d_hp), .COMP(comp), .SAMP(samp), .SAMP_analog(samp_an),
        .WP0(wp[0]), .WP1(wp[1]), .WP2(wp[2]), .WP3(wp[3]),
        .data_from_pre(data_from_pre), .data_to_post(data_to_post), .o_dbg_frame_cnt(dbg_cnt)
    );

    // ---------------- reference model / scoreboard ----------------
    int          n_vec;
    int          n_err;
    int          n_cyc;
    logic [11:0] m_reg [16];
    logic [11:0] m_res [4];
    bit          m_active;
    int          m_cnt;
    logic [3:0]  m_wp;
    logic [3:0]  m_status;
    logic [3:0]  m_amp_last;
    logic [12:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n_cyc, got, exp);
        end
    endtask

    function automatic bit m_selected(input logic [9:0] a, input bit is_write);
        if (a[9:8] == 2'b00 && a[7:0] == reg_map_addr) return 1'b1;
        return is_write && (a == 10'h3FF);
    endfunction

    function automatic logic [15:0] m_read_word(input logic [3:0] idx);
        if (idx <= 4'd12) return {4'h0, m_reg[idx]};
        if (idx == 4'd13) return {12'h000, m_status};
        return 16'h0000;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 12'h000;
        for (int i = 8; i < 12; i++) m_reg[i] = 12'h00F;
        for (int n = 0; n < 4; n++) m_res[n] = 12'h000;
        m_active = 1'b0; m_cnt = 0; m_wp = 4'h0; m_status = 4'h0; m_amp_last = 4'h0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(13'h1FFF);
    endtask

    task automatic m_edge();
        logic [3:0] idx;
        idx = bus.code[3:0];
        if (!m_active) begin
            m_active = 1'b1;
            m_cnt    = 0;
            m_wp     = 4'h0;
        end else begin
            // count 2+k captures result bit 11-k
            if (m_cnt >= 2 && m_cnt <= 13) begin
                for (int n = 0; n < 4; n++) m_res[n][13 - m_cnt] = comp[n];
                m_wp = comp;
            end else begin
                m_wp = 4'h0;
            end
            if (m_cnt == 15) begin
                exp_q.delete();
                for (int n = 0; n < 4; n++) exp_q.push_back(m_reg[n][0] ? {1'b0, m_res[n]} : 13'h0000);
            end else begin
                void'(exp_q.pop_front());
                exp_q.push_back(data_from_pre);
            end
            m_cnt = (m_cnt + 1) % 64;
        end
        if (bus.code[5:4] == 2'b01 && m_selected(bus.addr, 1'b1) && idx <= 4'd12)
            m_reg[idx] = bus.data_in[11:0];
        m_status   = m_amp_last;
        m_amp_last = amp_out;
    endtask

    task automatic check_all();
        logic [3:0][11:0] g_stim, g_sw, e_rec, e_stim, e_sw;
        logic [3:0]       e_az;
        bit               rd_exp;
        for (int n = 0; n < 4; n++) begin
            g_stim[n] = {amp_x50[n], amp_on[n], off_stim[n], stim_amp[n]};
            g_sw[n]   = {cb_chnl[n], sw_can[n], sw_ano_n[n]};
            e_rec[n]  = m_reg[n];
            e_stim[n] = m_reg[4 + n];
            e_sw[n]   = m_reg[8 + n];
            e_az[n]   = m_reg[4 + n][10] && ((m_cnt % 32) >= 16);
        end
        chk("rec",   64'(rec),    64'(e_rec));
        chk("stim",  64'(g_stim), 64'(e_stim));
        chk("sw",    64'(g_sw),   64'(e_sw));
        chk("misc",  64'({d_hp, elec_mux}), 64'(m_reg[12]));
        chk("az",    64'({az_clk_n, az_clk}), 64'({~e_az, e_az}));
        chk("seq",   64'({dbg_cnt, samp, samp_an, wp}),
                     64'({6'(m_cnt), m_active && (m_cnt < 2), m_active && (m_cnt < 3), m_wp}));
        chk("chain", 64'(data_to_post), 64'(exp_q[0]));
`ifdef BLOCK_DIGITAL_READBACK_EN
        rd_exp = (bus.code[5:4] == 2'b10) && m_selected(bus.addr, 1'b0);
        chk("oe", 64'(bus.data_oe), 64'(rd_exp));
        if (rd_exp) chk("rdata", 64'(data_out), 64'(m_read_word(bus.code[3:0])));
`else
        rd_exp = 1'b0;
        chk("oe", 64'(bus.data_oe), 64'(rd_exp));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk_3p2M);
        if (rst_n) m_edge();
        @(negedge clk_3p2M);
        n_cyc++;
        check_all();
    endtask

    task automatic drive(input logic [5:0] code, input logic [9:0] addr, input logic [15:0] din);
        bus.code = code; bus.addr = addr; bus.data_in = din;
    endtask

    task automatic drive_random();
        case ($urandom_range(0, 3))
            0:       bus.addr = 10'h005;
            1:       bus.addr = 10'h3FF;
            2:       bus.addr = 10'h006;
            default: bus.addr = 10'($urandom_range(0, 1023));
        endcase
        bus.code      = 6'($urandom_range(0, 63));
        bus.data_in   = 16'($urandom);
        comp          = 4'($urandom);
        data_from_pre = 13'($urandom);
        amp_out       = 4'($urandom);
    endtask

    task automatic wait_cnt(input logic [5:0] target, input int budget);
        for (int i = 0; i < budget && dbg_cnt != target; i++) cycle();
        chk("wait_cnt", 64'(dbg_cnt), 64'(target));
    endtask

    task automatic wait_az2(input logic level, output int at);
        logic prev;
        prev = az_clk[2];
        at   = -1000;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (az_clk[2] == level && prev != level) begin
                at = n_cyc;
                break;
            end
            prev = az_clk[2];
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t_r0, t_f0, t_r1;
        n_vec = 0; n_err = 0; n_cyc = 0;
        rst_n = 1'b1; reg_map_addr = 8'h05;
        drive(6'h00, 10'h000, 16'h0000);
        comp = 4'h0; data_from_pre = 13'h1FFF; amp_out = 4'h0;
        #2 rst_n = 1'b0;
        m_reset();
        @(negedge clk_3p2M);
        check_all();
        chk("rst_d2p",  64'(data_to_post), 64'(13'h1FFF));
        chk("rst_swan", 64'(sw_ano_n),     64'(16'hFFFF));
        chk("rst_azn",  64'(az_clk_n),     64'(4'hF));
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("first_samp", 64'({samp, dbg_cnt}), 64'({1'b1, 6'd0}));

        // Local write lands, neighbour address does not
        drive(6'h10, 10'h005, 16'h0ABC); cycle();
        chk("rec0_wr", 64'(rec[0]), 64'(12'hABC));
        drive(6'h10, 10'h006, 16'h0123); cycle();
        chk("rec0_hold", 64'(rec[0]), 64'(12'hABC));

        // Broadcast write to MISC, then readback of it
        drive(6'h1C, 10'h3FF, 16'h0F3A); cycle();
        chk("bc_mux", 64'(elec_mux), 64'(8'h3A));
        chk("bc_dhp", 64'(d_hp),     64'(4'hF));
        drive(6'h2C, 10'h005, 16'h0000);
        #1;
`ifdef BLOCK_DIGITAL_READBACK_EN
        chk("rb_misc", 64'(data_out), 64'(16'h0F3A));
`else
        chk("rb_off", 64'(bus.data_oe), 64'(1'b0));
`endif
        cycle();

        // Randomized traffic across many frames (includes 63->0 wraps)
        for (int i = 0; i < 700; i++) begin
            drive_random();
            cycle();
        end

        // Known conversion: all channels enabled, COMP = 0101
        drive(6'h00, 10'h000, 16'h0000);
        amp_out = 4'h0;
        for (int n = 0; n < 4; n++) begin
            drive({2'b01, 4'(n)}, 10'h3FF, 16'h0001);
            cycle();
        end
        drive(6'h00, 10'h000, 16'h0000);
        comp = 4'b0101; data_from_pre = 13'h1ABC;
        wait_cnt(6'd0, 70);
        wait_cnt(6'd16, 20);
        chk("d2p_c16", 64'(data_to_post), 64'(13'h0FFF)); cycle();
        chk("d2p_c17", 64'(data_to_post), 64'(13'h0000)); cycle();
        chk("d2p_c18", 64'(data_to_post), 64'(13'h0FFF)); cycle();
        chk("d2p_c19", 64'(data_to_post), 64'(13'h0000)); cycle();
        chk("d2p_c20", 64'(data_to_post), 64'(13'h1ABC));

        // STIM_2 enables the amplifier and its auto-zero clock
        drive(6'h16, 10'h005, 16'h0500); cycle();
        drive(6'h00, 10'h000, 16'h0000);
        chk("amp_on2", 64'(amp_on[2]),   64'(1'b1));
        chk("amp2",    64'(stim_amp[2]), 64'(9'h100));
        wait_az2(1'b1, t_r0);
        wait_az2(1'b0, t_f0);
        wait_az2(1'b1, t_r1);
        chk("az_high",   64'(t_f0 - t_r0), 64'(16));
        chk("az_period", 64'(t_r1 - t_r0), 64'(32));

        // AMP_OUT_2 pulse reaches STATUS after two clocks
        drive(6'h2D, 10'h005, 16'h0000);
        amp_out = 4'h0; cycle(); cycle();
        amp_out = 4'b0100; cycle();
        amp_out = 4'h0;
`ifdef BLOCK_DIGITAL_READBACK_EN
        chk("status_1clk", 64'(data_out), 64'(16'h0000));
`endif
        cycle();
`ifdef BLOCK_DIGITAL_READBACK_EN
        chk("status_2clk", 64'(data_out), 64'(16'h0004));
`endif
        drive(6'h00, 10'h000, 16'h0000);

        // Reset in the middle of a conversion
        comp = 4'($urandom);
        wait_cnt(6'd8, 70);
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all();
        chk("mid_rst_seq", 64'({samp, samp_an, wp, dbg_cnt}), 64'(0));
        chk("mid_rst_d2p", 64'(data_to_post), 64'(13'h1FFF));
        chk("mid_rst_az",  64'({az_clk_n, az_clk}), 64'(8'hF0));
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_rst_s0", 64'(samp), 64'(1'b1));
        cycle();
        chk("post_rst_s1", 64'(samp), 64'(1'b1));
        cycle();
        chk("post_rst_s2", 64'(samp), 64'(1'b0));
        for (int i = 0; i < 40; i++) begin
            drive_random();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d got=timeout exp=finish", n_cyc);
        $fatal(1);
    end

endmodule
